cpu_multicycle_controller: RTL

Multi-cycle control FSM for the RV32I core, the sequenced successor to the single-cycle main decoder. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Instruction and data memory use req/ready handshakes with wait states. An optional multi-cycle MUL/DIV unit is sequenced with a start/done handshake, and ECALL, EBREAK and illegal encodings raise precise traps. It sits between the instruction register (IR) and the datapath, and drives every datapath enable and mux select.

---
 rtl/cpu_ctrl_pkg.sv | 46 ++++
 rtl/cpu_instr_classifier.sv | 54 +++++
 rtl/cpu_multicycle_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_MULDIV_WAIT, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR,
    CLS_LUI, CLS_AUIPC, CLS_SYSTEM, CLS_FENCE, CLS_ILLEGAL
  } instr_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_LOAD = 2'b01;
  localparam logic [1:0] WB_SRC_PC4  = 2'b10;
  localparam logic [1:0] WB_SRC_IMM  = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_BRCMP = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

endpackage

// File: rtl/cpu_instr_classifier.sv
// Combinational instruction classifier: opcode class plus legality and trap kinds.
module cpu_instr_classifier
  import cpu_ctrl_pkg::*;
#(
  parameter bit SUPPORT_M   = 1'b0,
  parameter bit SUPPORT_CSR = 1'b1
) (
  input  logic [31:0]  instr,
  output instr_class_e cls,
  output logic         legal,
  output logic         is_muldiv,
  output logic         is_ecall,
  output logic         is_ebreak
);

  always_comb begin
    cls       = CLS_ILLEGAL;
    legal     = 1'b1;
    is_muldiv = 1'b0;
    is_ecall  = 1'b0;
    is_ebreak = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        cls = CLS_ALU_R;
        if (instr[31:25] == 7'b0000001) begin
          is_muldiv = SUPPORT_M;
          legal     = SUPPORT_M;
        end
      end
      OPC_OP_IMM: cls = CLS_ALU_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_FENCE:  cls = CLS_FENCE;
      OPC_SYSTEM: begin
        cls = CLS_SYSTEM;
        // funct3=000 is only legal as the exact ECALL/EBREAK words
        if (instr[14:12] == 3'b000) begin
          is_ecall  = (instr == ECALL_WORD);
          is_ebreak = (instr == EBREAK_WORD);
          legal     = (instr == ECALL_WORD) || (instr == EBREAK_WORD);
        end else begin
          legal = SUPPORT_CSR;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with handshaked memories,
// MUL/DIV sequencing and precise traps.
module cpu_multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter bit SUPPORT_M   = 1'b0,
  parameter bit SUPPORT_CSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  input  logic        muldiv_done,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  writeback_src,
  output logic [1:0]  ALU_op,
  output logic        ALU_src,
  output logic        alu_src1_is_pc,
  output logic        csr_read,
  output logic        muldiv_start,
  output logic        trap,
  output logic [3:0]  trap_cause,
  output logic        instret
);

  state_e       state_q, state_d;
  instr_class_e cls;
  logic         legal, is_muldiv, is_ecall, is_ebreak;

  cpu_instr_classifier #(
    .SUPPORT_M  (SUPPORT_M),
    .SUPPORT_CSR(SUPPORT_CSR)
  ) u_classifier (
    .instr    (instr),
    .cls      (cls),
    .legal    (legal),
    .is_muldiv(is_muldiv),
    .is_ecall (is_ecall),
    .is_ebreak(is_ebreak)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!legal || is_ecall || is_ebreak) state_d = ST_TRAP;
        else if (cls == CLS_FENCE)           state_d = ST_WB;
        else                                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH)                         state_d = ST_FETCH;
        else if (cls == CLS_LOAD || cls == CLS_STORE) state_d = ST_MEM;
        else if (is_muldiv)                            state_d = ST_MULDIV_WAIT;
        else                                           state_d = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready) state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_MULDIV_WAIT: if (muldiv_done) state_d = ST_WB;
      ST_WB:          state_d = ST_FETCH;
      ST_TRAP:        state_d = ST_FETCH;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req       = 1'b0;
    ir_write       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PC_SRC_PLUS4;
    reg_write      = 1'b0;
    writeback_src  = WB_SRC_ALU;
    ALU_op         = ALU_OP_ADD;
    ALU_src        = 1'b0;
    alu_src1_is_pc = 1'b0;
    csr_read       = 1'b0;
    muldiv_start   = 1'b0;
    trap           = 1'b0;
    trap_cause     = '0;
    instret        = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: ALU_op = ALU_OP_FUNCT;
          CLS_BRANCH:           ALU_op = ALU_OP_BRCMP;
          default:              ALU_op = ALU_OP_ADD;
        endcase
        ALU_src = (cls == CLS_ALU_I) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
                  (cls == CLS_JAL) || (cls == CLS_JALR) || (cls == CLS_LUI) ||
                  (cls == CLS_AUIPC);
        alu_src1_is_pc = (cls == CLS_AUIPC) || (cls == CLS_JAL);
        muldiv_start   = is_muldiv;
        if (cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          instret  = 1'b1;
          pc_src   = branch_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (cls == CLS_STORE && dmem_ready) begin
          pc_write = 1'b1;
          instret  = 1'b1;
        end
      end
      ST_WB: begin
        reg_write = (cls != CLS_FENCE);
        pc_write  = 1'b1;
        instret   = 1'b1;
        csr_read  = (cls == CLS_SYSTEM);
        case (cls)
          CLS_LOAD:             writeback_src = WB_SRC_LOAD;
          CLS_JAL, CLS_JALR:    writeback_src = WB_SRC_PC4;
          CLS_LUI, CLS_SYSTEM:  writeback_src = WB_SRC_IMM;
          default:              writeback_src = WB_SRC_ALU;
        endcase
        if (cls == CLS_JAL)       pc_src = PC_SRC_TARGET;
        else if (cls == CLS_JALR) pc_src = PC_SRC_JALR;
      end
      ST_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_SRC_TRAP;
        if (is_ecall)       trap_cause = CAUSE_ECALL;
        else if (is_ebreak) trap_cause = CAUSE_EBREAK;
        else                trap_cause = CAUSE_ILLEGAL;
      end
      default: ;
    endcase
  end

endmodule
